// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered NCH-channel stream multiplexer.
// Arbitration is either round-robin, starting from ptr_q, or fixed priority
// where the lowest index wins. The grant is combinational and the selected
// beat lands in a single output register stage.
//
// Handshake: a beat moves on channel i when in_val[i] and in_rdy[i] are both
// high at a rising edge. The producer holds data stable while valid is high
// and ready is low. The output side uses out_val/out_rdy the same way.
// in_rdy depends combinationally on out_rdy, so the register can be drained
// and reloaded on the same edge. in_data reaches the outputs only through
// the register.
module stream_mux_rr #(
  parameter int NCH = 4,
  parameter int W   = 32,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [NCH-1:0]   in_val,
  output logic [NCH-1:0]   in_rdy,
  input  logic [NCH*W-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_sel
);

  logic          out_val_q;
  logic [W-1:0]  out_data_q;
  logic [CW-1:0] out_sel_q;
  logic [CW-1:0] ptr_q;

  logic [NCH-1:0] grant;
  logic [CW-1:0]  gnt_idx;
  logic           gnt_found;
  logic [CW-1:0]  scan_idx;
  logic           space;
  logic           xfer;
  logic [CW-1:0]  ptr_d;
  logic [W-1:0]   load_data;

  // Space exists when the register is empty or is being drained this cycle.
  assign space = ~out_val_q | out_rdy;

  // Grant scan: start at ptr_q in round-robin mode, at 0 in fixed priority.
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = mode ? CW'(k) : CW'((int'(ptr_q) + k) % NCH);
      if (!gnt_found && in_val[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        gnt_idx         = scan_idx;
        gnt_found       = 1'b1;
      end
    end
  end

  // Ready follows the grant and available space; reset blocks every channel.
  always_comb begin
    in_rdy = '0;
    if (!rst && space) begin
      in_rdy = grant;
    end
  end

  assign xfer = gnt_found & space;

  // Next pointer is one past the winner. Indices wrap explicitly, so a
  // non-power-of-2 NCH also wraps.
  always_comb begin
    ptr_d     = ptr_q;
    load_data = in_data[int'(gnt_idx)*W +: W];
    if (xfer) begin
      ptr_d = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Output register and pointer. A load takes precedence over a plain drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      out_sel_q  <= '0;
      ptr_q      <= '0;
    end else if (xfer) begin
      out_val_q  <= 1'b1;
      out_data_q <= load_data;
      out_sel_q  <= gnt_idx;
      ptr_q      <= ptr_d;
    end else if (out_val_q && out_rdy) begin
      out_val_q  <= 1'b0;
    end
  end

  assign out_val  = out_val_q;
  assign out_data = out_data_q;
  assign out_sel  = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr with NCH=4 and W=8.
module tb_stream_mux_rr;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int CW  = 2;

  logic             clk;
  logic             rst;
  logic             mode;
  logic [NCH-1:0]   in_val;
  logic [NCH-1:0]   in_rdy;
  logic [NCH*W-1:0] in_data;
  logic             out_val;
  logic             out_rdy;
  logic [W-1:0]     out_data;
  logic [CW-1:0]    out_sel;

  int n_cmp;
  int n_bad;

  logic [W-1:0] exp_q[$];

  stream_mux_rr #(.NCH(NCH), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_sel  (out_sel)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to 1 ns past the next rising edge. Registered outputs are stable there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational ready settle after the inputs change.
  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; in_val = 4'b1111; out_rdy = 1'b1;
    in_data = {8'h33, 8'h22, 8'h11, 8'h00};
    settle();
    n_cmp++;
    if (in_rdy !== 4'b0000) begin
      n_bad++; $display("FAIL reset_rdy0 got=%b exp=0000", in_rdy);
    end
    tick();
    tick();
    n_cmp++;
    if (in_rdy !== 4'b0000) begin
      n_bad++; $display("FAIL reset_rdy1 got=%b exp=0000", in_rdy);
    end
    rst = 1'b0; in_val = 4'b0000;
    settle();
    n_cmp++;
    if (out_val !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
      n_bad++; $display("FAIL reset_state got val=%b data=%h sel=%0d exp 0/00/0", out_val, out_data, out_sel);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out_val !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0 || in_rdy !== 4'b0000) begin
        n_bad++; $display("FAIL idle_hold cyc=%0d got val=%b data=%h sel=%0d rdy=%b", i, out_val, out_data, out_sel, in_rdy);
      end
    end
  endtask

  // After this test ptr is 1.
  task automatic test_rr_rotation();
    logic [W-1:0] exp_d;
    logic [3:0]   exp_r;
    mode = 1'b0; out_rdy = 1'b1; in_val = 4'b1111;
    in_data = {8'h33, 8'h22, 8'h11, 8'h00};
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(8'(8'h11 * (k % 4)));
    end
    for (int k = 0; k < 5; k++) begin
      settle();
      exp_r = 4'(1 << (k % 4));
      n_cmp++;
      if (in_rdy !== exp_r) begin
        n_bad++; $display("FAIL rr_rdy k=%0d got=%b exp=%b", k, in_rdy, exp_r);
      end
      tick();
      exp_d = exp_q.pop_front();
      n_cmp++;
      if (out_val !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== exp_d) begin
        n_bad++; $display("FAIL rr_out k=%0d got val=%b sel=%0d data=%h exp 1/%0d/%h", k, out_val, out_sel, out_data, k % 4, exp_d);
      end
    end
    in_val = 4'b0000;
    tick();
    n_cmp++;
    if (out_val !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
      n_bad++; $display("FAIL rr_drain got val=%b data=%h sel=%0d exp 0/00/0", out_val, out_data, out_sel);
    end
  endtask

  // Enters with ptr=1 and leaves with ptr=3.
  task automatic test_sparse_wrap();
    mode = 1'b0; out_rdy = 1'b1;
    in_val = 4'b0100;
    tick();
    n_cmp++;
    if (out_sel !== 2'd2 || out_data !== 8'h22) begin
      n_bad++; $display("FAIL sparse_setup got sel=%0d data=%h exp 2/22", out_sel, out_data);
    end
    in_val = 4'b0101;
    settle();
    n_cmp++;
    if (in_rdy !== 4'b0001) begin
      n_bad++; $display("FAIL sparse_wrap_rdy got=%b exp=0001", in_rdy);
    end
    tick();
    n_cmp++;
    if (out_val !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h00) begin
      n_bad++; $display("FAIL sparse_wrap_out got val=%b sel=%0d data=%h exp 1/0/00", out_val, out_sel, out_data);
    end
    n_cmp++;
    if (in_rdy !== 4'b0100) begin
      n_bad++; $display("FAIL sparse_next_rdy got=%b exp=0100", in_rdy);
    end
    tick();
    n_cmp++;
    if (out_sel !== 2'd2 || out_data !== 8'h22) begin
      n_bad++; $display("FAIL sparse_next_out got sel=%0d data=%h exp 2/22", out_sel, out_data);
    end
    in_val = 4'b0000;
    tick();
  endtask

  // Enters with ptr=3 and leaves with ptr=3.
  task automatic test_fixed_prio();
    mode = 1'b1; out_rdy = 1'b1; in_val = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_cmp++;
      if (in_rdy !== 4'b0010) begin
        n_bad++; $display("FAIL fp_rdy cyc=%0d got=%b exp=0010", i, in_rdy);
      end
      tick();
      n_cmp++;
      if (out_val !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h11) begin
        n_bad++; $display("FAIL fp_out cyc=%0d got val=%b sel=%0d data=%h exp 1/1/11", i, out_val, out_sel, out_data);
      end
    end
    mode = 1'b0;
    settle();
    n_cmp++;
    if (in_rdy !== 4'b0100) begin
      n_bad++; $display("FAIL fp_to_rr_rdy got=%b exp=0100", in_rdy);
    end
    tick();
    n_cmp++;
    if (out_sel !== 2'd2 || out_data !== 8'h22) begin
      n_bad++; $display("FAIL fp_to_rr_out got sel=%0d data=%h exp 2/22", out_sel, out_data);
    end
    in_val = 4'b0000;
    tick();
  endtask

  // Enters with ptr=3. Loads 0xAA from ch1, so ptr becomes 2.
  task automatic test_backpressure();
    mode = 1'b0; out_rdy = 1'b1;
    in_data = {8'h33, 8'h22, 8'hAA, 8'h00};
    in_val = 4'b0010;
    tick();
    n_cmp++;
    if (out_val !== 1'b1 || out_data !== 8'hAA || out_sel !== 2'd1) begin
      n_bad++; $display("FAIL bp_load got val=%b data=%h sel=%0d exp 1/aa/1", out_val, out_data, out_sel);
    end
    out_rdy = 1'b0; in_val = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++;
      if (in_rdy !== 4'b0000) begin
        n_bad++; $display("FAIL bp_rdy cyc=%0d got=%b exp=0000", i, in_rdy);
      end
      tick();
      n_cmp++;
      if (out_val !== 1'b1 || out_data !== 8'hAA || out_sel !== 2'd1) begin
        n_bad++; $display("FAIL bp_hold cyc=%0d got val=%b data=%h sel=%0d exp 1/aa/1", i, out_val, out_data, out_sel);
      end
    end
    out_rdy = 1'b1;
    settle();
    n_cmp++;
    if (in_rdy !== 4'b0100) begin
      n_bad++; $display("FAIL bp_release_rdy got=%b exp=0100", in_rdy);
    end
    tick();
    n_cmp++;
    if (out_val !== 1'b1 || out_data !== 8'h22 || out_sel !== 2'd2) begin
      n_bad++; $display("FAIL bp_drain_load got val=%b data=%h sel=%0d exp 1/22/2", out_val, out_data, out_sel);
    end
  endtask

  // Enters with ptr=3 and a valid entry held.
  task automatic test_reset_mid();
    out_rdy = 1'b0; in_val = 4'b1111;
    tick();
    rst = 1'b1;
    settle();
    n_cmp++;
    if (in_rdy !== 4'b0000) begin
      n_bad++; $display("FAIL rmid_rdy got=%b exp=0000", in_rdy);
    end
    tick();
    rst = 1'b0;
    n_cmp++;
    if (out_val !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
      n_bad++; $display("FAIL rmid_state got val=%b data=%h sel=%0d exp 0/00/0", out_val, out_data, out_sel);
    end
    out_rdy = 1'b1;
    settle();
    n_cmp++;
    if (in_rdy !== 4'b0001) begin
      n_bad++; $display("FAIL rmid_ptr_rdy got=%b exp=0001", in_rdy);
    end
    tick();
    n_cmp++;
    if (out_val !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h00) begin
      n_bad++; $display("FAIL rmid_next got val=%b sel=%0d data=%h exp 1/0/00", out_val, out_sel, out_data);
    end
    in_val = 4'b0000;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; mode = 1'b0; in_val = '0; out_rdy = 1'b0; in_data = '0;
    #1;
    test_reset();
    test_rr_rotation();
    test_sparse_wrap();
    test_fixed_prio();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised, registered N-channel stream multiplexer with valid/ready handshakes and selectable round-robin or fixed-priority arbitration. It generalises the single-bit two-input gate-level mux into a W-bit, NCH-input sequential selector with one output register stage. It sits between multiple producers (fetch, memory response, debug) and a single consumer port in the processor datapath.

## Interface

- NCH, default 4: number of input channels, legal 2..8.
- W, default 32: data width per channel, in bits.
- CW, derived, equal to max(1, clog2(NCH)): width of the channel index.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- in_val  in  NCH  per-channel valid.
- in_rdy  out  NCH  per-channel ready; at most one bit is high in any cycle.
- in_data  in  NCH*W  channel i occupies bits [i*W +: W].
- out_val  out  1  output register holds a valid entry.
- out_rdy  in  1  consumer accepts the output entry.
- out_data  out  W  registered data.
- out_sel  out  CW  index of the channel that produced out_data.

## Operation

- State:
  - Output register: out_val, out_data, out_sel.
  - Round-robin pointer ptr, CW bits, holding the highest-priority index.
- Space:
  - space = ~out_val | out_rdy.
  - The register can accept a new entry in the same cycle it is drained.
- Grant is combinational, one-hot or zero:
  - mode=0: the first i with in_val[i]=1, scanning ptr, ptr+1, …, NCH-1, 0, …, ptr-1 (mod NCH).
  - mode=1: the lowest i with in_val[i]=1; ptr is ignored.
  - No in_val bit set means no grant.
- Ready: in_rdy[i] = grant[i] & space.
  - There is a combinational path from out_rdy to in_rdy; this is intended.
  - No combinational path exists from in_data to any output.
- Transfer happens on channel g when in_val[g] & in_rdy[g]. On the next edge:
  - out_val=1, out_data=in_data[g], out_sel=g.
  - ptr = (g+1) mod NCH. With non-power-of-2 NCH, NCH-1 wraps to 0.
  - ptr updates in both modes, so a switch to mode 0 resumes fairly from the last winner.
- Drain without transfer (out_val & out_rdy, no grant): out_val←0. out_data and out_sel hold their last values.
- No transfer and no drain: all state holds.
- in_val deasserted while in_rdy is low: legal, and nothing is consumed. Producers are expected to hold data stable while valid and not ready, but the block does not check this.
- mode may change on any cycle and takes effect on that cycle's grant.

## Timing

- Reset (rst=1 at an edge): out_val=0, out_data=0, out_sel=0, ptr=0.
  - in_rdy is forced to all-zero while rst=1.
  - A held entry is discarded, including one present mid-transfer.
- Latency: input transfer at edge n, then out_val=1 and data visible after edge n.
- Throughput: one transfer per cycle while out_rdy=1.
- Backpressure: with out_val=1 and out_rdy=0:
  - All in_rdy=0.
  - The output register holds and ptr holds.
- Fairness: in mode 0 with all channels continuously valid and out_rdy=1, each channel is granted exactly once every NCH cycles.
- Starvation: in mode 1, higher-index channels may starve. This is permitted.

## Test plan

- Reset and idle, NCH=4, W=8: assert rst for 2 cycles with all in_val=1, then in_val=0 → during reset in_rdy=0000. After reset out_val=0, out_data=0x00, out_sel=0, and outputs hold while idle.
- Round-robin rotation: mode=0, in_val=1111, in_data={0x33,0x22,0x11,0x00}, out_rdy=1 → out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 0x00,0x11,0x22,0x33,0x00, one per cycle.
- Sparse round-robin wrap: mode=0, ptr=3, in_val=0101 → grant ch0 (in_rdy=0001). On the next cycle ptr=1, so in_val=0101 grants ch2.
- Fixed priority: mode=1, in_val=1110 for 4 cycles, out_rdy=1 → out_sel=1 every cycle. Then switch to mode=0 → the next grant is ch2 (ptr=2).
- Backpressure: entry 0xAA from ch1 held, out_rdy=0 for 3 cycles with in_val=1111 → in_rdy=0000, out_data stays 0xAA, ptr unchanged. Raising out_rdy=1 then gives simultaneous drain and load of ch2's data on the same edge, with out_val staying 1.
- Reset mid-operation: out_val=1 with out_rdy=0, then pulse rst for 1 cycle → out_val=0 and ptr=0. The next grant with in_val=1111 is ch0.
